// File: rtl/conv_v_window_sequencer.sv
// conv_v_window_sequencer: raster fp16 pixel stream -> vertical WINDOW_HEIGHT x 1 windows.
// Owns the line buffers and the frame col/row counters; window_o[0][0] is the oldest row.
// Optional feature: define CONV_SEQ_WIN_COUNT_EN to add the win_count_o per-frame window counter.
module conv_v_window_sequencer #(
  parameter int unsigned EXP_WIDTH     = 5,
  parameter int unsigned FRAC_WIDTH    = 10,
  parameter int unsigned WINDOW_HEIGHT = 9,
  parameter int unsigned IMAGE_WIDTH   = 640,
  parameter int unsigned IMAGE_HEIGHT  = 480,
  localparam int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] pixel_i,
  input  logic                    valid_i,
  input  logic                    sof_i,
  output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][1],
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o,
  output logic                    frame_done_o,
  output logic                    abort_o
`ifdef CONV_SEQ_WIN_COUNT_EN
  ,
  output logic [31:0]             win_count_o
`endif
);

  localparam int unsigned LB_ROWS = WINDOW_HEIGHT - 1;
  localparam int unsigned SLOT_W  = $clog2(LB_ROWS);
  localparam int unsigned COL_W   = $clog2(IMAGE_WIDTH);
  localparam int unsigned HALF    = (WINDOW_HEIGHT - 1) / 2;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STREAM} state_t;

  state_t                  state;
  logic [15:0]             col;
  logic [15:0]             row;
  logic [SLOT_W-1:0]       ptr;
  logic [FP_WIDTH_REG-1:0] line_buf [LB_ROWS][IMAGE_WIDTH];

  logic                    accept;
  logic                    start;
  logic                    row_end;
  logic [SLOT_W-1:0]       wr_slot;
  logic [COL_W-1:0]        wr_col;

  // Physical slot holding the k-th oldest buffered row, given the oldest slot.
  function automatic logic [SLOT_W-1:0] slot_of(input logic [SLOT_W-1:0] base,
                                                input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= LB_ROWS) s = s - LB_ROWS;
    return SLOT_W'(s);
  endfunction

  // Accept qualification and line-buffer write address; sof always lands at slot 0, col 0.
  always_comb begin
    accept  = valid_i && ((state != ST_IDLE) || sof_i);
    start   = valid_i && sof_i;
    row_end = (col == 16'(IMAGE_WIDTH - 1));
    wr_slot = ptr;
    wr_col  = COL_W'(col);
    if (start) begin
      wr_slot = '0;
      wr_col  = '0;
    end
  end

  // Line buffer write; contents survive reset, reads below see the pre-write value.
  always_ff @(posedge clk_i) begin
    if (accept) line_buf[wr_slot][wr_col] <= pixel_i;
  end

  // Frame sequencing FSM, counters and registered window outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      col          <= '0;
      row          <= '0;
      ptr          <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      abort_o      <= 1'b0;
      col_o        <= '0;
      row_o        <= '0;
      for (int unsigned k = 0; k < WINDOW_HEIGHT; k++) window_o[k][0] <= '0;
`ifdef CONV_SEQ_WIN_COUNT_EN
      win_count_o  <= '0;
`endif
    end else begin
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      abort_o      <= 1'b0;
      if (start) begin
        // New frame: this pixel is (0,0); mid-frame sof is an abort and suppresses frame_done.
        abort_o <= (state != ST_IDLE);
        state   <= ST_FILL;
        col     <= 16'd1;
        row     <= '0;
        ptr     <= '0;
`ifdef CONV_SEQ_WIN_COUNT_EN
        win_count_o <= '0;
`endif
      end else if (accept) begin
        if (state == ST_STREAM) begin
          valid_o <= 1'b1;
          col_o   <= col;
          row_o   <= row - 16'(HALF);
          for (int unsigned k = 0; k < LB_ROWS; k++)
            window_o[k][0] <= line_buf[slot_of(ptr, k)][COL_W'(col)];
          window_o[LB_ROWS][0] <= pixel_i;
`ifdef CONV_SEQ_WIN_COUNT_EN
          if (win_count_o != 32'hFFFF_FFFF) win_count_o <= win_count_o + 32'd1;
`endif
        end
        if (row_end) begin
          col <= '0;
          row <= row + 16'd1;
          ptr <= (ptr == SLOT_W'(LB_ROWS - 1)) ? '0 : ptr + SLOT_W'(1);
          if ((state == ST_FILL) && (row == 16'(WINDOW_HEIGHT - 2))) state <= ST_STREAM;
          if ((state == ST_STREAM) && (row == 16'(IMAGE_HEIGHT - 1))) begin
            state        <= ST_IDLE;
            frame_done_o <= 1'b1;
            row          <= '0;
            ptr          <= '0;
          end
        end else begin
          col <= col + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_v_window_sequencer.sv
// Bench for conv_v_window_sequencer with a 4x4 frame and a 3-row window; pixels are fp16 of raster index.
module tb_conv_v_window_sequencer;

  localparam int WH   = 3;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int FPW  = 16;
  localparam int NPIX = IW * IH;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [FPW-1:0] pixel_i;
  logic           valid_i;
  logic           sof_i;
  logic [FPW-1:0] window_o [WH][1];
  logic [15:0]    col_o;
  logic [15:0]    row_o;
  logic           valid_o;
  logic           frame_done_o;
  logic           abort_o;
`ifdef CONV_SEQ_WIN_COUNT_EN
  logic [31:0]    win_count_o;
  logic [31:0]    fd_wc;
`endif

  conv_v_window_sequencer #(
    .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_HEIGHT(WH), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .pixel_i(pixel_i),
    .valid_i(valid_i),
    .sof_i(sof_i),
    .window_o(window_o),
    .col_o(col_o),
    .row_o(row_o),
    .valid_o(valid_o),
    .frame_done_o(frame_done_o),
    .abort_o(abort_o)
`ifdef CONV_SEQ_WIN_COUNT_EN
    ,
    .win_count_o(win_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the frame as a 2-D image indexed by raster position.
  bit             in_frame;
  int             idx;
  logic [FPW-1:0] img [IH][IW];
  logic           e_valid, e_fd, e_ab;
  logic [FPW-1:0] e_win [WH];
  logic [15:0]    e_col, e_row;
  logic [31:0]    e_wc;
  bit             chk_en;

  // Observed statistics per test.
  int             n_win, n_fd, n_ab;
  logic [FPW-1:0] first_win [WH];
  logic [FPW-1:0] last_win [WH];
  logic [15:0]    first_col, first_row, last_col, last_row;

  function automatic logic [15:0] fp16(input int n);
    int e;
    if (n <= 0) return 16'h0000;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return 16'(((15 + e) << 10) | ((n - (1 << e)) << (10 - e)));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic s, input logic [15:0] p);
    int r, c;
    e_valid = 1'b0;
    e_fd    = 1'b0;
    e_ab    = 1'b0;
    if (v && s) begin
      e_ab      = in_frame;
      in_frame  = 1'b1;
      img[0][0] = p;
      idx       = 1;
      e_wc      = 32'd0;
    end else if (v && in_frame) begin
      r = idx / IW;
      c = idx % IW;
      img[r][c] = p;
      if (r >= WH - 1) begin
        e_valid = 1'b1;
        for (int k = 0; k < WH; k++) e_win[k] = img[r - (WH - 1) + k][c];
        e_col = 16'(c);
        e_row = 16'(r - (WH - 1) / 2);
        e_fd  = (idx == NPIX - 1);
        e_wc  = e_wc + 32'd1;
      end
      idx++;
      if (idx == NPIX) in_frame = 1'b0;
    end
  endtask

  task automatic px(input logic v, input logic s, input int n);
    @(negedge clk_i);
    valid_i = v;
    sof_i   = s;
    pixel_i = fp16(n);
    model_step(v, s, fp16(n));
  endtask

  task automatic clear_stats();
    n_win = 0;
    n_fd  = 0;
    n_ab  = 0;
  endtask

  task automatic run_frame(input bit toggle);
    for (int n = 0; n < NPIX; n++) begin
      px(1'b1, n == 0, n);
      if (toggle) px(1'b0, 1'b0, 0);
    end
    px(1'b0, 1'b0, 0);
    px(1'b0, 1'b0, 0);
  endtask

  task automatic check_frame(input string tag, input int nwin, input int nab);
    chk({tag, " window count"}, 32'(n_win), 32'(nwin));
    chk({tag, " frame_done count"}, 32'(n_fd), 32'd1);
    chk({tag, " abort count"}, 32'(n_ab), 32'(nab));
    chk({tag, " first win0"}, 32'(first_win[0]), 32'h0000);
    chk({tag, " first win1"}, 32'(first_win[1]), 32'h4400);
    chk({tag, " first win2"}, 32'(first_win[2]), 32'h4800);
    chk({tag, " first col"}, 32'(first_col), 32'd0);
    chk({tag, " first row"}, 32'(first_row), 32'd1);
    chk({tag, " last win0"}, 32'(last_win[0]), 32'h4700);
    chk({tag, " last win1"}, 32'(last_win[1]), 32'h4980);
    chk({tag, " last win2"}, 32'(last_win[2]), 32'h4B80);
    chk({tag, " last col"}, 32'(last_col), 32'd3);
    chk({tag, " last row"}, 32'(last_row), 32'd2);
`ifdef CONV_SEQ_WIN_COUNT_EN
    chk({tag, " win_count at frame_done"}, fd_wc, 32'd8);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " valid_o"}, 32'(valid_o), 32'd0);
    chk({tag, " frame_done_o"}, 32'(frame_done_o), 32'd0);
    chk({tag, " abort_o"}, 32'(abort_o), 32'd0);
    chk({tag, " col_o"}, 32'(col_o), 32'd0);
    chk({tag, " row_o"}, 32'(row_o), 32'd0);
    for (int k = 0; k < WH; k++) chk($sformatf("%s window_o[%0d]", tag, k), 32'(window_o[k][0]), 32'd0);
`ifdef CONV_SEQ_WIN_COUNT_EN
    chk({tag, " win_count_o"}, win_count_o, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i    = 1'b0;
    valid_i  = 1'b1;
    sof_i    = 1'b0;
    pixel_i  = fp16(10);
    in_frame = 1'b0;
    idx      = 0;
    e_valid  = 1'b0;
    e_fd     = 1'b0;
    e_ab     = 1'b0;
    e_wc     = 32'd0;
    #1;
    check_zero("async reset");
    repeat (2) @(negedge clk_i);
    rst_i   = 1'b1;
    valid_i = 1'b0;
  endtask

  // Per-cycle comparison of DUT outputs against the model, plus statistics capture.
  always @(posedge clk_i) begin
    #1;
    if (chk_en) begin
      chk("valid_o", 32'(valid_o), 32'(e_valid));
      chk("abort_o", 32'(abort_o), 32'(e_ab));
      chk("frame_done_o", 32'(frame_done_o), 32'(e_fd));
      if (e_valid) begin
        for (int k = 0; k < WH; k++)
          chk($sformatf("window_o[%0d]", k), 32'(window_o[k][0]), 32'(e_win[k]));
        chk("col_o", 32'(col_o), 32'(e_col));
        chk("row_o", 32'(row_o), 32'(e_row));
      end
`ifdef CONV_SEQ_WIN_COUNT_EN
      chk("win_count_o", win_count_o, e_wc);
      if (frame_done_o) fd_wc = win_count_o;
`endif
      if (valid_o) begin
        n_win++;
        if (n_win == 1) begin
          for (int k = 0; k < WH; k++) first_win[k] = window_o[k][0];
          first_col = col_o;
          first_row = row_o;
        end
        for (int k = 0; k < WH; k++) last_win[k] = window_o[k][0];
        last_col = col_o;
        last_row = row_o;
      end
      if (frame_done_o) n_fd++;
      if (abort_o) n_ab++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i    = 1'b0;
    valid_i  = 1'b0;
    sof_i    = 1'b0;
    pixel_i  = '0;
    chk_en   = 1'b0;
    in_frame = 1'b0;
    idx      = 0;
    e_valid  = 1'b0;
    e_fd     = 1'b0;
    e_ab     = 1'b0;
    e_wc     = 32'd0;
    e_col    = '0;
    e_row    = '0;
    for (int k = 0; k < WH; k++) e_win[k] = '0;
    clear_stats();
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset state");
    @(negedge clk_i);
    rst_i  = 1'b1;
    chk_en = 1'b1;

    // Continuous full frame.
    clear_stats();
    run_frame(1'b0);
    check_frame("continuous", 8, 0);

    // valid_i toggling every cycle.
    clear_stats();
    run_frame(1'b1);
    check_frame("toggled", 8, 0);

    // Pixels without sof while idle are ignored.
    clear_stats();
    for (int n = 0; n < 6; n++) px(1'b1, 1'b0, n + 3);
    px(1'b0, 1'b0, 0);
    chk("idle ignored window count", 32'(n_win), 32'd0);
    run_frame(1'b0);
    check_frame("after idle", 8, 0);

    // sof at raster index 9 aborts and restarts the frame.
    clear_stats();
    for (int n = 0; n < 9; n++) px(1'b1, n == 0, n);
    run_frame(1'b0);
    check_frame("abort", 9, 1);

    // Reset at raster index 10, then a fresh frame.
    clear_stats();
    for (int n = 0; n < 10; n++) px(1'b1, n == 0, n);
    do_reset();
    px(1'b1, 1'b0, 5);
    run_frame(1'b0);
    check_frame("mid-frame reset", 10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
